// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with an RV32-style funct decode.
// Single-cycle ops (add/sub/logic/shift/compare) and illegal decodes complete
// one cycle after accept. M-extension multiply/divide iterate one bit per
// cycle (shift-add / restoring) and complete XLEN+1 cycles after accept.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   ALUOp, funct3,
//   inst30/25/5           operation select and instruction decode fields
//   op_a, op_b            operands (op_b[SHW-1:0] is the shift amount)
//   flush                 synchronous abort back to IDLE
//   out_valid / out_ready result handshake (valid only in DONE)
//   result, illegal       registered result and illegal-decode flag
module alu_seq_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            inst30,
  input  logic            inst25,
  input  logic            inst5,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     result_q;
  logic                illegal_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2:0]          mop_q;
  logic                qneg_q;
  logic                rneg_q;

  // ---------------------------------------------------------------- decode
  logic [SHW-1:0]  shamt;
  logic            alt;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] dec_res;
  logic            dec_illegal;
  logic            dec_mop;

  assign shamt   = op_b[SHW-1:0];
  // Kept separate so the arithmetic shift is not turned logical by mixing
  // signed and unsigned operands inside a conditional expression.
  assign sra_res = $unsigned($signed(op_a) >>> shamt);

  always_comb begin
    dec_res     = '0;
    dec_illegal = 1'b0;
    dec_mop     = 1'b0;
    // Immediate forms only honour inst30 for the right shift; ADDI must not
    // become a subtract.
    alt = inst5 ? inst30 : (inst30 && (funct3 == 3'b101));
    unique case (funct3)
      3'b000:  alu_res = alt ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = alt ? sra_res : (op_a >> shamt);
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
    unique case (ALUOp)
      2'b00: dec_res = op_a + op_b;
      2'b01: dec_res = op_a - op_b;
      2'b11: dec_res = op_b;
      default: begin
        if (!inst5) begin
          dec_res = alu_res;
        end else if (!inst25) begin
          if (inst30 && (funct3 != 3'b000) && (funct3 != 3'b101))
            dec_illegal = 1'b1;
          else
            dec_res = alu_res;
        end else if (inst30) begin
          dec_illegal = 1'b1;
        end else begin
          dec_mop = 1'b1;
        end
      end
    endcase
  end

  // ------------------------------------------------------ M-op preparation
  logic            m_div;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, m_fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    m_div    = funct3[2];
    a_sgn    = m_div ? ~funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
    b_sgn    = m_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = a_neg ? ('0 - op_a) : op_a;
    b_mag    = b_neg ? ('0 - op_b) : op_b;
    div_zero = m_div && (op_b == '0);
    div_ovf  = m_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    m_fast   = div_zero | div_ovf;
    if (div_zero)
      fast_res = funct3[1] ? op_a : '1;
    else
      fast_res = funct3[1] ? '0 : op_a;
  end

  // ------------------------------------------------- iterative datapath
  // acc_q holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_rs, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_acc;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fin_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_rs - {1'b0, opnd_q};
    div_ge   = ~div_diff[XLEN];
    div_acc  = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    acc_d    = mop_q[2] ? div_acc : mul_acc;
    prod     = qneg_q ? ('0 - acc_d) : acc_d;
    quo      = acc_d[XLEN-1:0];
    rem      = acc_d[2*XLEN-1:XLEN];
    unique case (mop_q)
      3'b000:                 fin_d = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_d = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_d = qneg_q ? ('0 - quo) : quo;
      default:                fin_d = rneg_q ? ('0 - rem) : rem;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      mop_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (dec_mop && !m_fast) begin
              state_q <= CALC;
              cnt_q   <= CW'(XLEN - 1);
              mop_q   <= funct3;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              if (m_div) begin
                acc_q  <= {{XLEN{1'b0}}, a_mag};
                opnd_q <= b_mag;
              end else begin
                acc_q  <= {{XLEN{1'b0}}, b_mag};
                opnd_q <= a_mag;
              end
            end else begin
              state_q   <= DONE;
              illegal_q <= dec_illegal;
              result_q  <= dec_mop ? fast_res : dec_res;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q   <= DONE;
            result_q  <= fin_d;
            illegal_q <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        inst30, inst25, inst5;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .inst30(inst30), .inst25(inst25),
    .inst5(inst5), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, accept it on the next edge, then scramble inputs.
  task automatic send(input logic [1:0] aop, input logic [2:0] f3,
                      input logic i30, input logic i25, input logic i5,
                      input logic [31:0] a, input logic [31:0] b);
    ALUOp = aop; funct3 = f3; inst30 = i30; inst25 = i25; inst5 = i5;
    op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; funct3 = ~f3; ALUOp = ~aop; inst30 = ~i30;
  endtask

  task automatic do_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                       input logic i30, input logic i25, input logic i5,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill,
                       input int exp_cyc, input int hold);
    int cyc;
    send(aop, f3, i30, i25, i5, a, b);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      check({tag, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
      tick();
      cyc++;
    end
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    check({tag, "_done_rdy"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      check({tag, "_hold_v"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_res"}, result, exp_res);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_ret_v"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ret_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; ALUOp = '0; funct3 = '0;
    inst30 = 1'b0; inst25 = 1'b0; inst5 = 1'b0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    check("rst_v", {31'b0, out_valid}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_ill", {31'b0, illegal}, 32'd0);
    rst_n = 1'b1;

    // first edge after reset release accepts
    do_op("sub_r", 2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 0);
    do_op("add",   2'b00, 3'b111, 1, 1, 1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0);
    do_op("subop", 2'b01, 3'b010, 0, 1, 0, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1, 0);
    do_op("passb", 2'b11, 3'b101, 1, 1, 1, 32'hAAAA_0000, 32'h1234_5678, 32'h1234_5678, 0, 1, 0);
    do_op("addi30",2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7, 32'd12, 0, 1, 0);
    do_op("slti",  2'b10, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1, 0);
    do_op("sltiu", 2'b10, 3'b011, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0);
    do_op("sltu",  2'b10, 3'b011, 0, 0, 1, 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 1, 0);
    do_op("srai",  2'b10, 3'b101, 1, 0, 0, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1, 0);
    do_op("srli",  2'b10, 3'b101, 0, 0, 0, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1, 0);
    do_op("sll",   2'b10, 3'b001, 0, 0, 1, 32'd1, 32'h21, 32'd2, 0, 1, 0);
    do_op("xor",   2'b10, 3'b100, 0, 0, 1, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 0, 1, 0);
    do_op("ill_r", 2'b10, 3'b111, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 1, 0);
    do_op("ill_m", 2'b10, 3'b000, 1, 1, 1, 32'd3, 32'd4, 32'd0, 1, 1, 0);

    do_op("mulh_min", 2'b10, 3'b001, 0, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 33, 0);
    do_op("mul",      2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0, 33, 0);
    do_op("mulh_m1",  2'b10, 3'b001, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 33, 0);
    do_op("mulhu",    2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 0);
    do_op("mulhsu",   2'b10, 3'b010, 0, 1, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, 33, 0);
    do_op("div",      2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 33, 0);
    do_op("rem",      2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 33, 0);
    do_op("rem_nb",   2'b10, 3'b110, 0, 1, 1, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 33, 0);
    do_op("divu",     2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd7, 32'd14, 0, 33, 0);
    do_op("remu",     2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd7, 32'd2, 0, 33, 0);
    do_op("divu_z",   2'b10, 3'b101, 0, 1, 1, 32'd55, 32'd0, 32'hFFFF_FFFF, 0, 1, 0);
    do_op("remu_z",   2'b10, 3'b111, 0, 1, 1, 32'h1234, 32'd0, 32'h1234, 0, 1, 0);
    do_op("div_ovf",  2'b10, 3'b100, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0);
    do_op("rem_ovf",  2'b10, 3'b110, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 0);

    // consumer stalls for 5 cycles while new requests are offered
    do_op("stall", 2'b00, 3'b000, 0, 0, 0, 32'd40, 32'd2, 32'd42, 0, 1, 5);

    // flush during CALC cycle 10
    send(2'b10, 3'b001, 0, 1, 1, 32'h8000_0000, 32'h8000_0000);
    repeat (9) tick();
    check("fl_calc_rdy", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rdy", {31'b0, in_ready}, 32'd1);
    check("fl_v", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid === 1'b1) seen = 1;
    end
    check("fl_no_valid", seen, 32'd0);

    // flush overrides a simultaneous accept
    ALUOp = 2'b00; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("fl_acc_rdy", {31'b0, in_ready}, 32'd1);
    check("fl_acc_v", {31'b0, out_valid}, 32'd0);

    // flush discards a pending result in DONE
    send(2'b00, 3'b000, 0, 0, 0, 32'd9, 32'd9);
    check("fl_done_pre", {31'b0, out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_done_v", {31'b0, out_valid}, 32'd0);
    check("fl_done_rdy", {31'b0, in_ready}, 32'd1);

    // leave a nonzero result, then reset in the middle of a divide
    do_op("pre_rst", 2'b11, 3'b000, 0, 0, 0, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1, 0);
    send(2'b10, 3'b100, 0, 1, 1, 32'd1000, 32'd3);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_rdy", {31'b0, in_ready}, 32'd1);
    check("mrst_v", {31'b0, out_valid}, 32'd0);
    check("mrst_res", result, 32'd0);
    check("mrst_ill", {31'b0, illegal}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid === 1'b1) seen = 1;
    end
    check("mrst_hold", seen, 32'd0);
    rst_n = 1'b1;
    do_op("post_rst", 2'b10, 3'b110, 0, 0, 1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
